// File: rtl/ma_sched.sv
// Round-robin scheduler sharing one moving-average filter between NCH sample channels.
// Define MA_SCHED_STATS_EN to add the saturating flush_cnt output.
module ma_sched #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*WIDTH-1:0]    req_data,
  output logic [NCH-1:0]          req_ready,
  output logic                    flt_flush,
  output logic [WIDTH-1:0]        flt_in_data,
  output logic                    flt_in_valid,
  input  logic [WIDTH-1:0]        flt_out_data,
  input  logic                    flt_out_valid,
  output logic [WIDTH-1:0]        rsp_data,
  output logic                    rsp_valid,
  output logic [$clog2(NCH)-1:0]  rsp_ch,
  output logic                    busy
`ifdef MA_SCHED_STATS_EN
  ,
  output logic [15:0]             flush_cnt
`endif
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {IDLE, FLUSH, STREAM} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     grant_q, grant_d;
  logic [CW-1:0]     last_ch_q;
  logic              granted_q;
  logic [7:0]        cnt_q;
  logic [WIDTH-1:0]  rsp_data_q;
  logic              rsp_valid_q;
  logic [CW-1:0]     rsp_ch_q;

  logic [CW-1:0]     pick;
  logic              pick_found;
  int                rr_idx;
  logic [NCH-1:0]    grant_oh;
  logic              g_valid;
  logic              others_valid;
  logic              accept;
  logic              enter_stream;

  // Round-robin search starts one past the last streamed channel.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    rr_idx     = 0;
    for (int k = 1; k <= NCH; k++) begin
      rr_idx = int'(last_ch_q) + k;
      if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
      if (!pick_found && req_valid[rr_idx[CW-1:0]]) begin
        pick_found = 1'b1;
        pick       = rr_idx[CW-1:0];
      end
    end
  end

  assign grant_oh     = {{(NCH-1){1'b0}}, 1'b1} << grant_q;
  assign g_valid      = req_valid[grant_q];
  assign others_valid = |(req_valid & ~grant_oh);
  assign accept       = (state_q == STREAM) && g_valid;
  assign grant_d      = (state_q == IDLE && pick_found) ? pick : grant_q;
  assign enter_stream = (state_d == STREAM) && (state_q != STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_found)
          state_d = (pick != last_ch_q || !granted_q) ? FLUSH : STREAM;
      end
      FLUSH: state_d = STREAM;
      STREAM: begin
        if (accept && cnt_q == 8'(BURST - 1))
          state_d = IDLE;
        else if (!g_valid && others_valid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    flt_flush    = 1'b0;
    busy         = 1'b0;
    flt_in_valid = 1'b0;
    flt_in_data  = req_data[grant_q*WIDTH +: WIDTH];
    case (state_q)
      FLUSH: begin
        flt_flush = 1'b1;
        busy      = 1'b1;
      end
      STREAM: begin
        req_ready    = grant_oh;
        flt_in_valid = g_valid;
        busy         = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q   <= '0;
      last_ch_q <= CW'(NCH - 1);
      granted_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      grant_q <= grant_d;
      if (state_q == IDLE && pick_found) granted_q <= 1'b1;
      if (enter_stream) begin
        last_ch_q <= grant_d;
        cnt_q     <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // Result registers: data and channel only move with a valid filter result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ch_q    <= '0;
    end else begin
      rsp_valid_q <= flt_out_valid;
      if (flt_out_valid) begin
        rsp_data_q <= flt_out_data;
        rsp_ch_q   <= grant_q;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ch    = rsp_ch_q;

`ifdef MA_SCHED_STATS_EN
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flush_cnt_q <= '0;
    else if (state_q == IDLE && state_d == FLUSH && flush_cnt_q != 16'hFFFF)
      flush_cnt_q <= flush_cnt_q + 16'd1;
  end

  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ma_sched.sv
// Directed bench for ma_sched: channel drivers, a pass-through filter stub and a
// response scoreboard checked by an independent monitor.
module tb_ma_sched;
  localparam int NCH   = 4;
  localparam int W     = 8;
  localparam int BURST = 8;
  localparam int DEPTH = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NCH-1:0]     req_valid;
  logic [NCH*W-1:0]   req_data;
  logic [NCH-1:0]     req_ready;
  logic               flt_flush;
  logic [W-1:0]       flt_in_data;
  logic               flt_in_valid;
  logic [W-1:0]       flt_out_data = '0;
  logic               flt_out_valid = 1'b0;
  logic [W-1:0]       rsp_data;
  logic               rsp_valid;
  logic [1:0]         rsp_ch;
  logic               busy;
`ifdef MA_SCHED_STATS_EN
  logic [15:0]        flush_cnt;
`endif

  always #5 clk = ~clk;

  ma_sched #(.NCH(NCH), .WIDTH(W), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .flt_flush(flt_flush), .flt_in_data(flt_in_data), .flt_in_valid(flt_in_valid),
    .flt_out_data(flt_out_data), .flt_out_valid(flt_out_valid),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .busy(busy)
`ifdef MA_SCHED_STATS_EN
    , .flush_cnt(flush_cnt)
`endif
  );

  // Filter stub: one-cycle pass-through.
  always @(posedge clk) begin
    flt_out_valid <= flt_in_valid;
    flt_out_data  <= flt_in_data;
  end

  typedef struct { int ch; int data; } rsp_t;
  rsp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mem [NCH][DEPTH];
  int n   [NCH];
  int ptr [NCH];
  int cyc = 0;
  int flush_seen = 0;
  int flush_cyc = 0;
  int acc_cyc[$];
  int acc_ch[$];
  logic [W-1:0] mon_prev = '0;
  logic         mon_fov_prev = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_ch", rsp_ch, 0);
        mon_prev = '0;
      end else begin
        if (rsp_valid || mon_fov_prev) chk("rsp_latency", rsp_valid, mon_fov_prev);
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got ch=%0d data=%0d expected none", rsp_ch, rsp_data);
          end else begin
            e = exp_q.pop_front();
            $display("rsp ch=%0d data=0x%02h (exp ch=%0d data=0x%02h)", rsp_ch, rsp_data, e.ch, e.data);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_ch", rsp_ch, e.ch);
          end
          mon_prev = rsp_data;
        end else begin
          chk("rsp_hold", rsp_data, mon_prev);
        end
      end
      mon_fov_prev = flt_out_valid;
    end
  end

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      if (ptr[i] < n[i]) begin
        req_valid[i]       = 1'b1;
        req_data[i*W +: W] = mem[i][ptr[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*W +: W] = '0;
      end
    end
  endtask

  task automatic load(int ch, int base, int step, int cnt);
    for (int k = 0; k < cnt; k++) mem[ch][n[ch] + k] = W'(base + k * step);
    n[ch] = n[ch] + cnt;
  endtask

  task automatic push_exp(int ch, int base, int step, int cnt);
    rsp_t e;
    for (int k = 0; k < cnt; k++) begin
      e.ch   = ch;
      e.data = (base + k * step) & 8'hFF;
      exp_q.push_back(e);
    end
  endtask

  task automatic cycle();
    logic [NCH-1:0] hs;
    @(negedge clk);
    cyc++;
    hs = req_valid & req_ready;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_flush", flt_flush, 0);
    end
    if (flt_flush) begin
      flush_seen++;
      flush_cyc = cyc;
      chk("flush_ready", req_ready, 0);
      chk("flush_busy", busy, 1);
    end
    chk("ready_onehot", int'($countones(req_ready) <= 1), 1);
    chk("in_valid", flt_in_valid, int'(|hs));
    for (int i = 0; i < NCH; i++) begin
      if (hs[i]) begin
        acc_cyc.push_back(cyc);
        acc_ch.push_back(i);
        chk("in_data", flt_in_data, mem[i][ptr[i]]);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) if (hs[i]) ptr[i]++;
    drive();
  endtask

  task automatic run(int ncyc);
    for (int k = 0; k < ncyc; k++) cycle();
  endtask

  task automatic start_test();
    flush_seen = 0;
    acc_cyc.delete();
    acc_ch.delete();
  endtask

  // Expected gap between consecutive accepts: 1 inside a burst, bgap after every
  // per-th accept, sgap at index si.
  task automatic chk_gaps(string name, int per, int bgap, int si, int sgap);
    int e;
    for (int i = 1; i < acc_cyc.size(); i++) begin
      if (i == si)          e = sgap;
      else if (i % per == 0) e = bgap;
      else                  e = 1;
      chk(name, acc_cyc[i] - acc_cyc[i-1], e);
    end
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      n[i] = 0;
      ptr[i] = 0;
      for (int k = 0; k < DEPTH; k++) mem[i][k] = '0;
    end
    req_valid = '0;
    req_data  = '0;
    drive();
    run(3);

    // A: ch0 samples 10,20,30 after reset release.
    start_test();
    load(0, 10, 10, 3);
    push_exp(0, 10, 10, 3);
    drive();
    rst_n = 1'b1;
    run(12);
    chk("A_flushes", flush_seen, 1);
    chk("A_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() > 0) chk("A_flush_to_first", acc_cyc[0] - flush_cyc, 1);
    chk_gaps("A_gap", 100, 1, -1, 0);
    chk("A_drain", exp_q.size(), 0);

    // B: ch1 and ch2 alternate full bursts.
    start_test();
    load(1, 'h40, 1, 16);
    load(2, 'h80, 1, 16);
    push_exp(1, 'h40, 1, 8);
    push_exp(2, 'h80, 1, 8);
    push_exp(1, 'h48, 1, 8);
    push_exp(2, 'h88, 1, 8);
    drive();
    run(55);
    chk("B_flushes", flush_seen, 4);
    chk("B_accepts", acc_cyc.size(), 32);
    chk_gaps("B_gap", BURST, 3, -1, 0);
    chk("B_drain", exp_q.size(), 0);

    // C: ch3 alone, 20 samples: bursts 8,8,4 with single bubbles.
    start_test();
    load(3, 'hC0, 1, 20);
    push_exp(3, 'hC0, 1, 20);
    drive();
    run(32);
    chk("C_flushes", flush_seen, 1);
    chk("C_accepts", acc_cyc.size(), 20);
    chk_gaps("C_gap", BURST, 2, -1, 0);
    chk("C_drain", exp_q.size(), 0);

    // D: ch0 stops after 3 samples while ch2 waits.
    start_test();
    load(0, 'h01, 1, 3);
    load(2, 'h21, 1, 2);
    push_exp(0, 'h01, 1, 3);
    push_exp(2, 'h21, 1, 2);
    drive();
    run(16);
    chk("D_flushes", flush_seen, 2);
    chk("D_accepts", acc_cyc.size(), 5);
    chk_gaps("D_gap", 100, 1, 3, 4);
    chk("D_drain", exp_q.size(), 0);

    // E: reset in the middle of a ch1 burst.
    start_test();
    load(1, 'h51, 1, 3);
    push_exp(1, 'h51, 1, 3);
    drive();
    run(14);
    chk("E_pre_flushes", flush_seen, 1);
    chk("E_pre_accepts", acc_cyc.size(), 3);
    chk("E_busy_mid_burst", busy, 1);
    chk("E_pre_drain", exp_q.size(), 0);
    rst_n = 1'b0;
    load(1, 'h54, 1, 3);
    drive();
    run(2);
    start_test();
    push_exp(1, 'h54, 1, 3);
    rst_n = 1'b1;
    run(12);
    chk("E_flushes", flush_seen, 1);
    chk("E_accepts", acc_cyc.size(), 3);
    if (acc_cyc.size() > 0) begin
      chk("E_flush_to_first", acc_cyc[0] - flush_cyc, 1);
      chk("E_first_ch", acc_ch[0], 1);
    end
    chk("E_drain", exp_q.size(), 0);

    // F: after reset, a grant to ch3 (equal to reset last_ch) still flushes.
    rst_n = 1'b0;
    run(2);
    start_test();
    load(3, 'hE1, 1, 2);
    push_exp(3, 'hE1, 1, 2);
    drive();
    rst_n = 1'b1;
    run(10);
    chk("F_flushes", flush_seen, 1);
    chk("F_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() > 0) chk("F_flush_to_first", acc_cyc[0] - flush_cyc, 1);
    chk("F_drain", exp_q.size(), 0);

    // G: ch0/ch1 alternating bursts; four more switches.
    start_test();
    load(0, 'h60, 1, 16);
    load(1, 'h70, 1, 16);
    push_exp(0, 'h60, 1, 8);
    push_exp(1, 'h70, 1, 8);
    push_exp(0, 'h68, 1, 8);
    push_exp(1, 'h78, 1, 8);
    drive();
    run(55);
    chk("G_flushes", flush_seen, 4);
    chk("G_accepts", acc_cyc.size(), 32);
    chk_gaps("G_gap", BURST, 3, -1, 0);
    chk("G_drain", exp_q.size(), 0);
`ifdef MA_SCHED_STATS_EN
    chk("G_flush_cnt", flush_cnt, 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ma_sched.md
MA_SCHED -- requirements
Module: ma_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, number of requesting channels (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, sample width in bits.
REQ-003 SHALL have parameter BURST, default 8, maximum samples accepted per grant (1..255).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  NCH  per-channel sample valid.
REQ-007 SHALL have port req_data  input  NCH*WIDTH  per-channel samples; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready  output  NCH  per-channel accept; a sample transfers when valid and ready are both high.
REQ-009 SHALL have port flt_flush  output  1  one-cycle history clear to the shared moving-average filter.
REQ-010 SHALL have port flt_in_data  output  WIDTH  sample to the filter.
REQ-011 SHALL have port flt_in_valid  output  1  filter sample strobe.
REQ-012 SHALL have port flt_out_data  input  WIDTH  filter result.
REQ-013 SHALL have port flt_out_valid  input  1  filter result strobe.
REQ-014 SHALL have port rsp_data  output  WIDTH  registered filter result.
REQ-015 SHALL have port rsp_valid  output  1  result strobe.
REQ-016 SHALL have port rsp_ch  output  $clog2(NCH)  channel that owns rsp_data.
REQ-017 SHALL have port busy  output  1  high in FLUSH or STREAM.

Function
REQ-018 SHALL implement states IDLE, FLUSH, STREAM.
REQ-019 IDLE: if any req_valid is high, SHALL grant round-robin starting at last_ch+1 (wrapping NCH-1 -> 0) and latch the grant; no grant while all req_valid are low.
REQ-020 IDLE -> FLUSH when the granted channel differs from last_ch or no grant has occurred since reset; otherwise IDLE -> STREAM directly.
REQ-021 FLUSH SHALL last exactly one cycle with flt_flush=1, all req_ready=0, then go to STREAM.
REQ-022 STREAM: req_ready[g]=1 for granted channel g only; flt_in_data=req_data[g] and flt_in_valid=req_valid[g], combinationally.
REQ-023 STREAM SHALL count accepted samples and return to IDLE after the cycle in which the count reaches BURST.
REQ-024 STREAM SHALL return to IDLE early when req_valid[g] is low and any other channel's req_valid is high; if no other channel requests, the grant is held.
REQ-025 last_ch SHALL update to g on entry to STREAM; the burst count SHALL clear on entry to STREAM.
REQ-026 rsp_valid, rsp_data and rsp_ch SHALL be registered from flt_out_valid, flt_out_data and g, respectively, with latency 1 cycle; rsp_data SHALL hold when rsp_valid is 0.
REQ-027 req_ready SHALL be all-zero in IDLE and FLUSH; the IDLE arbitration cycle SHALL add one bubble between grants.
REQ-028 A sample accepted in the last burst cycle together with a request on another channel SHALL complete normally; re-arbitration SHALL occur in the next IDLE cycle.

Reset
REQ-029 When rst_n is low, SHALL enter IDLE with last_ch=NCH-1, no grant since reset, burst count=0, rsp_valid=0, rsp_data=0, rsp_ch=0, flt_flush=0, busy=0, req_ready=0.
REQ-030 A reset asserted during STREAM SHALL abandon the burst immediately; the first grant after release SHALL pass through FLUSH.

Configuration
REQ-031 With macro MA_SCHED_STATS_EN defined, SHALL add output port flush_cnt, 16 bits, counting FLUSH entries, saturating at 0xFFFF, reset to 0.
REQ-032 Without MA_SCHED_STATS_EN, flush_cnt and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Reset release, then ch0 continuously valid with samples 10,20,30 -> one FLUSH pulse, then flt_in_data 10,20,30 on consecutive cycles, rsp_ch=0 one cycle after each flt_out_valid.
REQ-034 ch1 and ch2 continuously valid, BURST=8 -> ch1 gets 8 samples, one IDLE cycle, FLUSH, then ch2 gets 8 samples, then ch1 again.
REQ-035 ch3 only, continuously valid, 20 samples -> single FLUSH, bursts of 8, 8, 4 separated by one-cycle IDLE bubbles, no further FLUSH.
REQ-036 ch0 in STREAM drops valid after 3 samples while ch2 is valid -> IDLE next cycle, then FLUSH, then ch2 granted.
REQ-037 rst_n pulsed low mid-burst on ch1 -> busy=0 and req_ready=0 while reset is low; the next grant to ch1 asserts flt_flush.
REQ-038 With MA_SCHED_STATS_EN and alternating ch0/ch1 traffic, 5 switches -> flush_cnt=5; without the macro, the build has no flush_cnt port.
